// File: rtl/jogo_pkg.sv
// ============================================================================
// jogo_pkg : state codes shared by the game control unit, debug display, bench
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package jogo_pkg;

    localparam int ESTADO_W = 4;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        ESPERA      = 4'h2,
        REGISTRA    = 4'h3,
        COMPARA     = 4'h4,
        PROXIMO     = 4'h5,
        FIM_ACERTO  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_ERRO    = 4'hE
    } estado_t;

endpackage

`default_nettype wire

// File: rtl/contador_timeout.sv
// ============================================================================
// contador_timeout : saturating inactivity counter, fim flags the last cycle
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module contador_timeout #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fim
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] C_MAX    = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] C_ULTIMO = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] r_contagem;

    // Saturates at TIMEOUT_CYCLES so a long stay can never wrap back to fim.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_contagem <= '0;
        end else if (clear) begin
            r_contagem <= '0;
        end else if (enable && (r_contagem != C_MAX)) begin
            r_contagem <= r_contagem + TW'(1);
        end
    end

    assign fim = (r_contagem == C_ULTIMO);

endmodule

`default_nettype wire

// File: rtl/unidade_controle_jogo.sv
// ============================================================================
// unidade_controle_jogo : Moore FSM sequencing the memory-game datapath
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module unidade_controle_jogo
    import jogo_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       igual,
    input  logic       fimC,
    output logic       zeraC,
    output logic       contaC,
    output logic       zeraR,
    output logic       registraR,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    estado_t r_estado;
    estado_t w_proximo;
    logic    w_tmo_clear;
    logic    w_tmo_enable;
    logic    w_tmo_fim;

    contador_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_contador_timeout (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_tmo_clear),
        .enable (w_tmo_enable),
        .fim    (w_tmo_fim)
    );

    // A play clears the counter in the same edge that leaves ESPERA.
    assign w_tmo_clear  = (r_estado == PREPARACAO) || (r_estado == PROXIMO) ||
                          ((r_estado == ESPERA) && jogada_feita);
    assign w_tmo_enable = (r_estado == ESPERA);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_estado <= INICIAL;
        end else begin
            r_estado <= w_proximo;
        end
    end

    always_comb begin
        w_proximo = INICIAL;
        case (r_estado)
            INICIAL:     w_proximo = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  w_proximo = ESPERA;
            ESPERA: begin
                if (jogada_feita) begin
                    w_proximo = REGISTRA;
                end else if (w_tmo_fim) begin
                    w_proximo = FIM_TIMEOUT;
                end else begin
                    w_proximo = ESPERA;
                end
            end
            REGISTRA:    w_proximo = COMPARA;
            COMPARA: begin
                if (!igual) begin
                    w_proximo = FIM_ERRO;
                end else if (fimC) begin
                    w_proximo = FIM_ACERTO;
                end else begin
                    w_proximo = PROXIMO;
                end
            end
            PROXIMO:     w_proximo = ESPERA;
            FIM_ACERTO:  w_proximo = iniciar ? PREPARACAO : FIM_ACERTO;
            FIM_ERRO:    w_proximo = iniciar ? PREPARACAO : FIM_ERRO;
            FIM_TIMEOUT: w_proximo = iniciar ? PREPARACAO : FIM_TIMEOUT;
            default:     w_proximo = INICIAL;
        endcase
    end

    // Outputs decode only the registered state, keeping zeraC glitch-free.
    always_comb begin
        zeraC     = 1'b0;
        contaC    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        pronto    = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        case (r_estado)
            PREPARACAO: begin
                zeraC = 1'b1;
                zeraR = 1'b1;
            end
            REGISTRA:    registraR = 1'b1;
            PROXIMO:     contaC = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = r_estado;

endmodule

`default_nettype wire

// File: tb/tb_unidade_controle_jogo.sv
// ============================================================================
// tb_unidade_controle_jogo : scoreboard bench with a behavioural game model
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_unidade_controle_jogo;

    localparam int T = 20;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       jogada_feita = 1'b0;
    logic       igual;
    logic       fimC;
    logic       zeraC, contaC, zeraR, registraR;
    logic       pronto, acertou, errou, timeout;
    logic [3:0] db_estado;

    always #5 clock = ~clock;

    unidade_controle_jogo #(.TIMEOUT_CYCLES(T)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .jogada_feita (jogada_feita),
        .igual        (igual),
        .fimC         (fimC),
        .zeraC        (zeraC),
        .contaC       (contaC),
        .zeraR        (zeraR),
        .registraR    (registraR),
        .pronto       (pronto),
        .acertou      (acertou),
        .errou        (errou),
        .timeout      (timeout),
        .db_estado    (db_estado)
    );

    // Datapath model: ROM, address counter, play register, comparator
    logic [3:0] rom [16];
    logic [3:0] addr = 4'd0;
    logic [3:0] preg = 4'd0;
    logic [3:0] chaves = 4'd0;

    always @(posedge clock) begin
        if (zeraC) addr <= 4'd0;
        else if (contaC) addr <= addr + 4'd1;
        if (zeraR) preg <= 4'd0;
        else if (registraR) preg <= chaves;
    end
    assign igual = (rom[addr] == preg);
    assign fimC  = (addr == 4'd15);

    typedef struct {
        int estado;
        int ac;
        int er;
        int to;
        int ad;
        int nreg;
        int nconta;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   tests = 0;
    int   fails = 0;
    int   p_delay [16];
    logic [3:0] p_val [16];

    task automatic check(input string nm, input int act, input int expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Round outcome from the game rules: plays in order, wrong value or a wait
    // of T or more cycles ends the round, 16 good plays win it.
    task automatic model_push(output int plays);
        exp_t e;
        plays = 0;
        e = '{10, 1, 0, 0, 15, 16, 15};
        for (int k = 0; k < 16; k++) begin
            if (p_delay[k] >= T) begin
                e = '{13, 0, 0, 1, k, k, k};
                break;
            end
            plays++;
            if (p_val[k] != rom[k]) begin
                e = '{14, 0, 1, 0, k, k + 1, k};
                break;
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: counts datapath strobes and scores each round end
    int   m_reg = 0;
    int   m_conta = 0;
    logic pr_prev = 1'b0;

    always @(negedge clock) begin
        if (zeraC === 1'b1) begin
            m_reg = 0;
            m_conta = 0;
        end
        if (registraR === 1'b1) m_reg++;
        if (contaC === 1'b1) m_conta++;
        if (pronto === 1'b1 && pr_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_end", 1, 0);
            end else begin
                m_e = sb.pop_front();
                check("end_state", int'(db_estado), m_e.estado);
                check("end_acertou", int'(acertou), m_e.ac);
                check("end_errou", int'(errou), m_e.er);
                check("end_timeout", int'(timeout), m_e.to);
                check("end_addr", int'(addr), m_e.ad);
                check("end_registraR_count", m_reg, m_e.nreg);
                check("end_contaC_count", m_conta, m_e.nconta);
            end
        end
        pr_prev = pronto;
    end

    task automatic start_round();
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
    endtask

    task automatic wait_espera(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (db_estado == 4'h2) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_espera_bound", 0, 1);
    endtask

    task automatic play(input int d, input logic [3:0] v);
        repeat (d) @(negedge clock);
        chaves = v;
        jogada_feita = 1'b1;
        @(negedge clock);
        jogada_feita = 1'b0;
    endtask

    task automatic wait_end();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 4 * T + 60; i++) begin
            if (pronto === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!seen) check("round_end_bound", 0, 1);
    endtask

    task automatic run_round();
        int np;
        bit ok;
        model_push(np);
        start_round();
        for (int k = 0; k < np; k++) begin
            wait_espera(ok);
            if (!ok) return;
            play(p_delay[k], p_val[k]);
        end
        wait_end();
    endtask

    task automatic plan_correct();
        for (int k = 0; k < 16; k++) begin
            p_delay[k] = int'($urandom_range(0, 5));
            p_val[k]   = rom[k];
        end
    endtask

    function automatic logic [7:0] outs();
        return {zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int np;
        bit ok;
        for (int k = 0; k < 16; k++) rom[k] = 4'($urandom_range(0, 15));

        // Reset dominates iniciar
        reset = 1'b0;
        iniciar = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_state", int'(db_estado), 0);
        check("reset_outputs", int'(outs()), 0);
        iniciar = 1'b0;
        reset = 1'b1;

        // Full winning round
        plan_correct();
        run_round();

        // Play on the expiry cycle wins over timeout; then a timeout at address 1
        plan_correct();
        p_delay[0] = T - 1;
        p_delay[1] = T;
        model_push(np);
        start_round();
        wait_espera(ok);
        repeat (T - 1) @(negedge clock);
        chaves = p_val[0];
        jogada_feita = 1'b1;
        @(negedge clock);
        jogada_feita = 1'b0;
        check("expiry_play_state", int'(db_estado), 3);
        check("expiry_play_no_timeout", int'(timeout), 0);
        wait_espera(ok);
        repeat (T - 1) @(negedge clock);
        check("espera_at_minus1", int'(db_estado), 2);
        @(negedge clock);
        check("timeout_state", int'(db_estado), 13);
        check("timeout_flag", int'(timeout), 1);

        // Wrong play at address 3
        plan_correct();
        p_val[3] = rom[3] ^ 4'($urandom_range(1, 15));
        run_round();

        // Restart from FIM_ERRO
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        check("restart_prep_state", int'(db_estado), 1);
        check("restart_zeraC", int'(zeraC), 1);
        check("restart_zeraR", int'(zeraR), 1);
        @(negedge clock);
        check("restart_espera_state", int'(db_estado), 2);
        check("restart_addr", int'(addr), 0);
        check("restart_zeraC_off", int'(zeraC), 0);

        // Reset mid-ESPERA
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midreset_state", int'(db_estado), 0);
        check("midreset_outputs", int'(outs()), 0);
        reset = 1'b1;

        // Randomized rounds
        for (int r = 0; r < 10; r++) begin
            for (int k = 0; k < 16; k++) begin
                p_delay[k] = ($urandom_range(0, 19) == 0) ? T + 1 : int'($urandom_range(0, T - 1));
                p_val[k]   = ($urandom_range(0, 19) == 0) ? (rom[k] ^ 4'($urandom_range(1, 15))) : rom[k];
            end
            if (r < 2) plan_correct();
            run_round();
        end

        repeat (2) @(negedge clock);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
